// File: rtl/filter_mode_scheduler.sv
// -----------------------------------------------------------------------------
// filter_mode_scheduler
//
// Decides which filter mode drives the video filter datapath. Mode requests
// are held as pending until the next frame boundary so the active mode never
// changes mid-frame. After each mode change (and after reset) a fixed number of
// pixel strobes is discarded while the filter pipeline refills. Only then is
// the filter output flagged as ready for display.
//
// Ports
//   clk_25MHz          in   1  pixel clock; all state changes on its rising edge
//   rst_n              in   1  synchronous active-low reset
//   mode_req           in   3  requested filter mode code
//   mode_req_valid     in   1  one-cycle strobe qualifying mode_req
//   frame_start        in   1  one-cycle pulse at the start of each frame
//   pixel_valid        in   1  active-video pixel strobe
//   active_filter_mode out  3  mode currently driving the filter datapath
//   filter_ready       out  1  filter output valid for display (RUN only)
//   mode_busy          out  1  a requested mode is waiting to be applied
//   req_err            out  1  one-cycle pulse after an illegal request
//   frame_count        out  8  frame_start pulses since reset (wraps)
// -----------------------------------------------------------------------------
module filter_mode_scheduler #(
  parameter int NUM_MODES    = 5,
  parameter int DEFAULT_MODE = 0,
  parameter int FLUSH_PX     = 9
) (
  input  logic       clk_25MHz,
  input  logic       rst_n,
  input  logic [2:0] mode_req,
  input  logic       mode_req_valid,
  input  logic       frame_start,
  input  logic       pixel_valid,
  output logic [2:0] active_filter_mode,
  output logic       filter_ready,
  output logic       mode_busy,
  output logic       req_err,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  localparam logic [3:0] NUM_MODES_W    = 4'(NUM_MODES);
  localparam logic [2:0] DEFAULT_MODE_W = 3'(DEFAULT_MODE);
  localparam logic [9:0] FLUSH_TARGET   = 10'(FLUSH_PX);

  // A mode code is legal when it lies below the number of implemented modes.
  function automatic logic mode_is_legal(input logic [2:0] code);
    mode_is_legal = ({1'b0, code} < NUM_MODES_W);
  endfunction

  state_t     state_q, state_d;
  logic [2:0] active_mode_q, active_mode_d;
  logic [2:0] pending_mode_q, pending_mode_d;
  // Tracks a request latched during FLUSH; always set while in PENDING.
  logic       pending_vld_q, pending_vld_d;
  logic [9:0] flush_cnt_q, flush_cnt_d;
  logic       filter_ready_q, filter_ready_d;
  logic       mode_busy_q, mode_busy_d;
  logic       req_err_q, req_err_d;
  logic [7:0] frame_count_q, frame_count_d;

  logic       req_legal_s;
  logic [9:0] flush_cnt_inc_s;

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    state_d         = state_q;
    active_mode_d   = active_mode_q;
    pending_mode_d  = pending_mode_q;
    pending_vld_d   = pending_vld_q;
    flush_cnt_d     = flush_cnt_q;
    req_legal_s     = mode_req_valid && mode_is_legal(mode_req);
    req_err_d       = mode_req_valid && !mode_is_legal(mode_req);
    flush_cnt_inc_s = flush_cnt_q + 10'd1;

    // Frame counter runs in every state and wraps naturally at 8 bits.
    if (frame_start) begin
      frame_count_d = frame_count_q + 8'd1;
    end else begin
      frame_count_d = frame_count_q;
    end

    case (state_q)
      ST_RUN: begin
        // A request for the mode already active is a no-op.
        if (req_legal_s && (mode_req != active_mode_q)) begin
          pending_mode_d = mode_req;
          pending_vld_d  = 1'b1;
          state_d        = ST_PENDING;
        end else begin
          pending_vld_d  = 1'b0;
          state_d        = ST_RUN;
        end
      end

      ST_PENDING: begin
        if (frame_start) begin
          // A request arriving with the frame boundary wins over the held one.
          if (req_legal_s) begin
            active_mode_d = mode_req;
          end else begin
            active_mode_d = pending_mode_q;
          end
          pending_vld_d = 1'b0;
          flush_cnt_d   = 10'd0;
          state_d       = ST_FLUSH;
        end else if (req_legal_s) begin
          // Overwrite even when equal to the active mode: it gets re-applied.
          pending_mode_d = mode_req;
          pending_vld_d  = 1'b1;
        end else begin
          pending_vld_d  = 1'b1;
        end
      end

      ST_FLUSH: begin
        if (req_legal_s) begin
          pending_mode_d = mode_req;
          pending_vld_d  = 1'b1;
        end else begin
          pending_vld_d  = pending_vld_q;
        end
        // frame_start deliberately has no effect on the flush count here.
        if (pixel_valid) begin
          if (flush_cnt_inc_s == FLUSH_TARGET) begin
            flush_cnt_d = 10'd0;
            if (pending_vld_d) begin
              state_d = ST_PENDING;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            flush_cnt_d = flush_cnt_inc_s;
          end
        end else begin
          flush_cnt_d = flush_cnt_q;
        end
      end

      default: begin
        pending_vld_d = 1'b0;
        flush_cnt_d   = 10'd0;
        state_d       = ST_FLUSH;
      end
    endcase

    filter_ready_d = (state_d == ST_RUN);
    mode_busy_d    = pending_vld_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      state_q        <= ST_FLUSH;
      active_mode_q  <= DEFAULT_MODE_W;
      pending_mode_q <= DEFAULT_MODE_W;
      pending_vld_q  <= 1'b0;
      flush_cnt_q    <= 10'd0;
      filter_ready_q <= 1'b0;
      mode_busy_q    <= 1'b0;
      req_err_q      <= 1'b0;
      frame_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      active_mode_q  <= active_mode_d;
      pending_mode_q <= pending_mode_d;
      pending_vld_q  <= pending_vld_d;
      flush_cnt_q    <= flush_cnt_d;
      filter_ready_q <= filter_ready_d;
      mode_busy_q    <= mode_busy_d;
      req_err_q      <= req_err_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign active_filter_mode = active_mode_q;
  assign filter_ready       = filter_ready_q;
  assign mode_busy          = mode_busy_q;
  assign req_err            = req_err_q;
  assign frame_count        = frame_count_q;

endmodule

// File: tb/tb_filter_mode_scheduler.sv
// -----------------------------------------------------------------------------
// tb_filter_mode_scheduler
//
// Scoreboard bench for filter_mode_scheduler. Each scenario task queues one
// stimulus entry per clock together with the outputs expected just after that
// clock edge, then drives the queue and compares the DUT outputs against the
// popped expectation. frame_count expectations are derived from the frame
// pulses the bench itself issues.
// -----------------------------------------------------------------------------
module tb_filter_mode_scheduler;

  logic       clk_25MHz;
  logic       rst_n;
  logic [2:0] mode_req;
  logic       mode_req_valid;
  logic       frame_start;
  logic       pixel_valid;
  logic [2:0] active_filter_mode;
  logic       filter_ready;
  logic       mode_busy;
  logic       req_err;
  logic [7:0] frame_count;

  filter_mode_scheduler #(
    .NUM_MODES   (5),
    .DEFAULT_MODE(0),
    .FLUSH_PX    (9)
  ) dut (
    .clk_25MHz         (clk_25MHz),
    .rst_n             (rst_n),
    .mode_req          (mode_req),
    .mode_req_valid    (mode_req_valid),
    .frame_start       (frame_start),
    .pixel_valid       (pixel_valid),
    .active_filter_mode(active_filter_mode),
    .filter_ready      (filter_ready),
    .mode_busy         (mode_busy),
    .req_err           (req_err),
    .frame_count       (frame_count)
  );

  // 25 MHz pixel clock.
  initial clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  typedef struct packed {
    logic       rst;
    logic [2:0] m;
    logic       mv;
    logic       fs;
    logic       pv;
  } stim_t;

  typedef struct {
    string      tag;
    logic [2:0] mode;
    logic       ready;
    logic       busy;
    logic       err;
    logic [7:0] fc;
  } exp_t;

  stim_t      stim_q[$];
  exp_t       sb_q[$];
  logic [7:0] exp_fc;
  int         n_cmp;
  int         n_bad;

  // Queue one cycle of stimulus and the outputs expected after its clock edge.
  task automatic add(input string tag, input logic r, input logic [2:0] m,
                     input logic mv, input logic fs, input logic pv,
                     input logic [2:0] em, input logic er, input logic eb,
                     input logic ee);
    stim_t s;
    exp_t  e;
    s.rst = r; s.m = m; s.mv = mv; s.fs = fs; s.pv = pv;
    if (!r) exp_fc = 8'd0;
    else if (fs) exp_fc = exp_fc + 8'd1;
    e.tag = tag; e.mode = em; e.ready = er; e.busy = eb; e.err = ee; e.fc = exp_fc;
    stim_q.push_back(s);
    sb_q.push_back(e);
  endtask

  // Apply one stimulus entry and advance to just after the clock edge.
  task automatic drive_cycle(input stim_t s);
    rst_n          = s.rst;
    mode_req       = s.m;
    mode_req_valid = s.mv;
    frame_start    = s.fs;
    pixel_valid    = s.pv;
    @(posedge clk_25MHz);
    #1;
    rst_n          = 1'b1;
    mode_req       = 3'd0;
    mode_req_valid = 1'b0;
    frame_start    = 1'b0;
    pixel_valid    = 1'b0;
  endtask

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    add("rst_busy_inputs", 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    add("rst_hold",        1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      e = sb_q.pop_front();
      n_cmp++;
      if ({active_filter_mode, filter_ready, mode_busy, req_err, frame_count} !==
          {e.mode, e.ready, e.busy, e.err, e.fc}) begin
        n_bad++;
        $display("FAIL %s: got mode=%0d ready=%0b busy=%0b err=%0b fc=%0d, expected mode=%0d ready=%0b busy=%0b err=%0b fc=%0d",
                 e.tag, active_filter_mode, filter_ready, mode_busy, req_err, frame_count,
                 e.mode, e.ready, e.busy, e.err, e.fc);
      end
    end
  endtask

  task automatic test_initial_flush();
    stim_t s;
    exp_t  e;
    // Idle cycles between strobes must not advance the flush.
    for (int k = 1; k <= 9; k++) begin
      add("init_flush_pv",   1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, (k == 9), 1'b0, 1'b0);
      add("init_flush_idle", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, (k == 9), 1'b0, 1'b0);
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      e = sb_q.pop_front();
      n_cmp++;
      if ({active_filter_mode, filter_ready, mode_busy, req_err, frame_count} !==
          {e.mode, e.ready, e.busy, e.err, e.fc}) begin
        n_bad++;
        $display("FAIL %s: got mode=%0d ready=%0b busy=%0b err=%0b fc=%0d, expected mode=%0d ready=%0b busy=%0b err=%0b fc=%0d",
                 e.tag, active_filter_mode, filter_ready, mode_busy, req_err, frame_count,
                 e.mode, e.ready, e.busy, e.err, e.fc);
      end
    end
  endtask

  task automatic test_mode_switch();
    stim_t s;
    exp_t  e;
    add("sw_req4", 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++)
      add("sw_wait", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    add("sw_apply", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      add("sw_flush_a", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    add("sw_fs_in_flush", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    for (int k = 5; k <= 9; k++)
      add("sw_flush_b", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, (k == 9), 1'b0, 1'b0);
    add("sw_run", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      e = sb_q.pop_front();
      n_cmp++;
      if ({active_filter_mode, filter_ready, mode_busy, req_err, frame_count} !==
          {e.mode, e.ready, e.busy, e.err, e.fc}) begin
        n_bad++;
        $display("FAIL %s: got mode=%0d ready=%0b busy=%0b err=%0b fc=%0d, expected mode=%0d ready=%0b busy=%0b err=%0b fc=%0d",
                 e.tag, active_filter_mode, filter_ready, mode_busy, req_err, frame_count,
                 e.mode, e.ready, e.busy, e.err, e.fc);
      end
    end
  endtask

  task automatic test_illegal();
    stim_t s;
    exp_t  e;
    add("ill_req6",     1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1);
    add("ill_err_drop", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    add("same_mode",    1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    add("ill_req5",     1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1);
    add("ill_req7",     1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1);
    add("ill_idle",     1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      e = sb_q.pop_front();
      n_cmp++;
      if ({active_filter_mode, filter_ready, mode_busy, req_err, frame_count} !==
          {e.mode, e.ready, e.busy, e.err, e.fc}) begin
        n_bad++;
        $display("FAIL %s: got mode=%0d ready=%0b busy=%0b err=%0b fc=%0d, expected mode=%0d ready=%0b busy=%0b err=%0b fc=%0d",
                 e.tag, active_filter_mode, filter_ready, mode_busy, req_err, frame_count,
                 e.mode, e.ready, e.busy, e.err, e.fc);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    // Pending overwrite, request latched during flush, flush ending in PENDING.
    add("ow_req2", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    add("ow_req3", 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    add("ow_req4", 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    add("ow_req3b",1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0);
    add("ow_apply",1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      add("ow_flush", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    add("fl_req1", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    for (int k = 4; k <= 9; k++)
      add("fl_flush", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      add("fl_pending", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    add("fl_apply1", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++)
      add("fl_flush1", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, (k == 9), 1'b0, 1'b0);
    // Overwriting with the active mode still re-applies with a full flush.
    add("re_req2", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    add("re_req1", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    add("re_apply",1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++)
      add("re_flush", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, (k == 9), 1'b0, 1'b0);
    // Request together with frame_start in PENDING: the new code is applied.
    add("pf_req2", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0);
    add("pf_req3_fs", 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++)
      add("pf_flush", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, (k == 9), 1'b0, 1'b0);
    // Request together with frame_start in RUN: held until the next frame.
    add("rf_req0_fs", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++)
      add("rf_wait", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    add("rf_apply", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++)
      add("rf_flush", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, (k == 9), 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      e = sb_q.pop_front();
      n_cmp++;
      if ({active_filter_mode, filter_ready, mode_busy, req_err, frame_count} !==
          {e.mode, e.ready, e.busy, e.err, e.fc}) begin
        n_bad++;
        $display("FAIL %s: got mode=%0d ready=%0b busy=%0b err=%0b fc=%0d, expected mode=%0d ready=%0b busy=%0b err=%0b fc=%0d",
                 e.tag, active_filter_mode, filter_ready, mode_busy, req_err, frame_count,
                 e.mode, e.ready, e.busy, e.err, e.fc);
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    stim_t s;
    exp_t  e;
    add("wr_reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 257; k++)
      add("wr_frames", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    add("mr_req3", 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      add("mr_flush", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    add("mr_reset", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++)
      add("mr_reflush", 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, (k == 9), 1'b0, 1'b0);
    add("mr_run", 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      drive_cycle(s);
      e = sb_q.pop_front();
      n_cmp++;
      if ({active_filter_mode, filter_ready, mode_busy, req_err, frame_count} !==
          {e.mode, e.ready, e.busy, e.err, e.fc}) begin
        n_bad++;
        $display("FAIL %s: got mode=%0d ready=%0b busy=%0b err=%0b fc=%0d, expected mode=%0d ready=%0b busy=%0b err=%0b fc=%0d",
                 e.tag, active_filter_mode, filter_ready, mode_busy, req_err, frame_count,
                 e.mode, e.ready, e.busy, e.err, e.fc);
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    exp_fc         = 8'd0;
    rst_n          = 1'b0;
    mode_req       = 3'd0;
    mode_req_valid = 1'b0;
    frame_start    = 1'b0;
    pixel_valid    = 1'b0;
    test_reset();
    test_initial_flush();
    test_mode_switch();
    test_illegal();
    test_back_to_back();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
